// File: rtl/tc_pl_bus_arb_if.sv
// Requester-side and SPI-master-side signal bundle for tc_pl_bus_arb.
// slave = arbiter view, master = view of the blocks around the arbiter.
interface tc_pl_bus_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int SELW = 8,
    parameter int LENW = 8
);
    // requester side
    logic [NREQ-1:0]      req;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      req_dreq;
    logic [DW-1:0]        rx_data;
    logic [NREQ-1:0]      rx_valid;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 busy;

    // SPI master / CSN mux side
    logic                 spi_tx_idle;
    logic                 spi_tx_dreq;
    logic                 spi_tx_valid;
    logic [DW-1:0]        spi_tx_data;
    logic                 spi_rx_valid;
    logic [DW-1:0]        spi_rx_data;
    logic [SELW-1:0]      chip_sel;

    modport slave (
        input  req, req_sel, req_len, req_valid, req_data,
        input  spi_tx_idle, spi_tx_dreq, spi_rx_valid, spi_rx_data,
        output gnt, req_dreq, rx_data, rx_valid, done, err, busy,
        output spi_tx_valid, spi_tx_data, chip_sel
    );

    modport master (
        output req, req_sel, req_len, req_valid, req_data,
        output spi_tx_idle, spi_tx_dreq, spi_rx_valid, spi_rx_data,
        input  gnt, req_dreq, rx_data, rx_valid, done, err, busy,
        input  spi_tx_valid, spi_tx_data, chip_sel
    );
endinterface

// File: rtl/tc_pl_bus_arb.sv
// Round-robin arbiter + frame sequencer sharing one SPI master and CSN mux among NREQ requesters.
// Latency: req -> gnt 2 cycles from IDLE; req_valid -> spi_tx_valid 1 cycle; spi_rx -> rx_valid 1 cycle.
// Backpressure: bytes are pulled only on master dreq; a requester silent for TOUT cycles aborts the frame.
module tc_pl_bus_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int SELW = 8,
    parameter int LENW = 8,
    parameter int TOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    tc_pl_bus_arb_if.slave    bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_LOAD,
        ST_WAITB,
        ST_XFER,
        ST_ABORT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     g_q, g_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [LENW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [TW-1:0]     tout_q, tout_d;
    logic              abort_q, abort_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   dreq_q, dreq_d;
    logic [NREQ-1:0]   rxv_q, rxv_d;
    logic [DW-1:0]     rxd_q, rxd_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic              txv_q, txv_d;
    logic [DW-1:0]     txd_q, txd_d;
    logic [SELW-1:0]   sel_q, sel_d;

    // Winner search: first set req bit at or after the pointer, wrapping.
    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    int                cand_i;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        cand_i  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NREQ) begin
                cand_i = cand_i - NREQ;
            end
            cand = PW'(cand_i);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    logic [PW-1:0] ptr_inc;
    logic          g_valid;
    logic [DW-1:0] g_data;
    logic          rx_ok;
    logic          frame_end;

    assign ptr_inc   = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;
    assign g_valid   = bus.req_valid[g_q];
    assign g_data    = bus.req_data[g_q*DW +: DW];
    assign frame_end = (tx_cnt_q == len_q) && (rx_cnt_q == len_q) && bus.spi_tx_idle;
    // Received bytes are only routed once the frame has actually started on the wire.
    assign rx_ok     = busy_q && ((state_q == ST_WAITB) || (state_q == ST_XFER) ||
                                  (state_q == ST_ABORT) || (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        len_d    = len_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        tout_d   = tout_q;
        abort_d  = abort_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        sel_d    = sel_q;
        txd_d    = txd_q;
        rxd_d    = rxd_q;
        dreq_d   = '0;
        rxv_d    = '0;
        done_d   = '0;
        err_d    = '0;
        txv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((|bus.req) && bus.spi_tx_idle) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (win_vld) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    g_d            = win_idx;
                    sel_d          = bus.req_sel[win_idx*SELW +: SELW];
                    len_d          = bus.req_len[win_idx*LENW +: LENW];
                    busy_d         = 1'b1;
                    tx_cnt_d       = '0;
                    rx_cnt_d       = '0;
                    abort_d        = 1'b0;
                    state_d        = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (len_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    dreq_d  = gnt_q;
                    tout_d  = '0;
                    state_d = ST_WAITB;
                end
            end
            ST_WAITB: begin
                // A byte arriving on the expiry cycle still wins over the abort.
                if (g_valid) begin
                    txv_d    = 1'b1;
                    txd_d    = g_data;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    state_d  = ST_XFER;
                end else if (tout_q == TW'(TOUT - 1)) begin
                    err_d   = gnt_q;
                    abort_d = 1'b1;
                    state_d = ST_ABORT;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (frame_end) begin
                    state_d = ST_DONE;
                end else if (bus.spi_tx_dreq && (tx_cnt_q < len_q)) begin
                    dreq_d  = gnt_q;
                    tout_d  = '0;
                    state_d = ST_WAITB;
                end
            end
            ST_ABORT: begin
                if (bus.spi_tx_idle) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = abort_q ? '0 : gnt_q;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = ptr_inc;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rx_ok && bus.spi_rx_valid) begin
            rxv_d    = gnt_q;
            rxd_d    = bus.spi_rx_data;
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            g_q      <= '0;
            len_q    <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tout_q   <= '0;
            abort_q  <= 1'b0;
            gnt_q    <= '0;
            dreq_q   <= '0;
            rxv_q    <= '0;
            rxd_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            g_q      <= g_d;
            len_q    <= len_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tout_q   <= tout_d;
            abort_q  <= abort_d;
            gnt_q    <= gnt_d;
            dreq_q   <= dreq_d;
            rxv_q    <= rxv_d;
            rxd_q    <= rxd_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            txv_q    <= txv_d;
            txd_q    <= txd_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.req_dreq     = dreq_q;
    assign bus.rx_data      = rxd_q;
    assign bus.rx_valid     = rxv_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.busy         = busy_q;
    assign bus.spi_tx_valid = txv_q;
    assign bus.spi_tx_data  = txd_q;
    assign bus.chip_sel     = sel_q;

endmodule

// File: tb/tb_tc_pl_bus_arb.sv
// Directed bench for tc_pl_bus_arb: requester and SPI-master models run on negedge,
// scenario tasks drive req/len/sel/rst one tick after posedge and compare against hand-computed values.
module tb_tc_pl_bus_arb;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SELW = 8;
    localparam int LENW = 8;
    localparam int TOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_pl_bus_arb_if #(.NREQ(NREQ), .DW(DW), .SELW(SELW), .LENW(LENW)) bus ();

    tc_pl_bus_arb #(.NREQ(NREQ), .DW(DW), .SELW(SELW), .LENW(LENW), .TOUT(TOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]      rq_bytes [NREQ][8];
    int              rq_ptr   [NREQ];
    bit              rq_mute  [NREQ];
    int              dreq_cnt [NREQ];
    int              done_cnt [NREQ];
    int              err_cnt  [NREQ];
    logic [7:0]      tx_log [$];
    logic [7:0]      rx_log [$];
    logic [NREQ-1:0] gnt_log [$];
    int              overlap_cnt, rxbad_cnt, cs_change_cnt, busy_rise, gnt_cycles, done_not_idle;
    int              cyc, dreq_cyc, err_cyc;

    int              m_cnt, m_hang;
    logic [7:0]      m_byte;
    logic [NREQ-1:0] prev_gnt;
    logic            prev_busy;
    logic [7:0]      prev_cs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            rq_ptr[i] = 0; rq_mute[i] = 1'b0;
            dreq_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
        end
        tx_log.delete(); rx_log.delete(); gnt_log.delete();
        overlap_cnt = 0; rxbad_cnt = 0; cs_change_cnt = 0;
        busy_rise = 0; gnt_cycles = 0; done_not_idle = 0;
        dreq_cyc = 0; err_cyc = 0;
    endtask

    function automatic logic [31:0] pack_tx();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < tx_log.size() && i < 4; i++) v = {v[23:0], tx_log[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_rx();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < rx_log.size() && i < 4; i++) v = {v[23:0], rx_log[i]};
        return v;
    endfunction

    // Monitor, requester models and SPI master model (loopback MISO = MOSI).
    initial begin
        bus.req_valid = '0; bus.req_data = '0;
        bus.spi_tx_idle = 1'b1; bus.spi_tx_dreq = 1'b0;
        bus.spi_rx_valid = 1'b0; bus.spi_rx_data = '0;
        m_cnt = 0; m_hang = 0; m_byte = '0;
        prev_gnt = '0; prev_busy = 1'b0; prev_cs = '0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.gnt != '0 && prev_gnt == '0) gnt_log.push_back(bus.gnt);
            if ($countones(bus.gnt) > 1 || (prev_gnt != '0 && bus.gnt != '0 && bus.gnt != prev_gnt))
                overlap_cnt++;
            if (bus.gnt != '0) gnt_cycles++;
            if (bus.gnt != '0 && bus.gnt == prev_gnt && bus.chip_sel != prev_cs) cs_change_cnt++;
            if (bus.busy && !prev_busy) busy_rise++;
            if (bus.rx_valid != '0) begin
                if (bus.rx_valid != bus.gnt) rxbad_cnt++;
                rx_log.push_back(bus.rx_data);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.done[i]) begin
                    done_cnt[i]++;
                    if (!bus.spi_tx_idle) done_not_idle++;
                end
                if (bus.err[i]) begin err_cnt[i]++; err_cyc = cyc; end
                if (bus.req_dreq[i]) begin dreq_cnt[i]++; dreq_cyc = cyc; end
            end
            if (bus.spi_tx_valid) tx_log.push_back(bus.spi_tx_data);
            prev_gnt = bus.gnt; prev_busy = bus.busy; prev_cs = bus.chip_sel;

            bus.req_valid = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_dreq[i] && !rq_mute[i]) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = rq_bytes[i][rq_ptr[i] % 8];
                    rq_ptr[i]++;
                end
            end

            bus.spi_rx_valid = 1'b0;
            bus.spi_tx_dreq  = 1'b0;
            if (rst) begin
                m_cnt = 0; m_hang = 0; bus.spi_tx_idle = 1'b1;
            end else if (bus.spi_tx_valid) begin
                m_byte = bus.spi_tx_data; m_cnt = 2; m_hang = 0; bus.spi_tx_idle = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.spi_rx_valid = 1'b1; bus.spi_rx_data = m_byte;
                    bus.spi_tx_dreq  = 1'b1; m_hang = 4;
                end
            end else if (m_hang > 0) begin
                m_hang--;
                if (m_hang == 0) bus.spi_tx_idle = 1'b1;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.spi_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv: got %b want 0", bus.spi_tx_valid); end
        checks++; if (bus.chip_sel !== 8'h00) begin errors++; $display("FAIL reset_cs: got %h want 00", bus.chip_sel); end
        checks++; if ({bus.spi_tx_data, bus.rx_data} !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", {bus.spi_tx_data, bus.rx_data}); end
        checks++; if ({bus.done, bus.err, bus.rx_valid, bus.req_dreq} !== 16'h0000) begin errors++; $display("FAIL reset_pulses: got %h want 0000", {bus.done, bus.err, bus.rx_valid, bus.req_dreq}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_logs();
        rq_bytes[0][0] = 8'hA5; rq_bytes[0][1] = 8'h5A; rq_bytes[0][2] = 8'hFF;
        bus.req_sel[0*SELW +: SELW] = 8'h02; bus.req_len[0*LENW +: LENW] = 8'd3;
        bus.req[0] = 1'b1;
        for (int k = 0; k < 20 && bus.gnt == '0; k++) tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
        checks++; if (bus.chip_sel !== 8'h02) begin errors++; $display("FAIL single_cs: got %h want 02", bus.chip_sel); end
        bus.req[0] = 1'b0;
        for (int k = 0; k < 200 && done_cnt[0] == 0; k++) tick();
        repeat (3) tick();
        checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt[0]); end
        checks++; if (tx_log.size() !== 3 || pack_tx() !== 32'h00A55AFF) begin errors++; $display("FAIL single_tx: got %0d bytes %h want 3 bytes 00a55aff", tx_log.size(), pack_tx()); end
        checks++; if (rx_log.size() !== 3 || pack_rx() !== 32'h00A55AFF) begin errors++; $display("FAIL single_rx: got %0d bytes %h want 3 bytes 00a55aff", rx_log.size(), pack_rx()); end
        checks++; if (dreq_cnt[0] !== 3) begin errors++; $display("FAIL single_dreq: got %0d want 3", dreq_cnt[0]); end
        checks++; if ({cs_change_cnt, rxbad_cnt, done_not_idle} !== {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL single_stable: cs_changes %0d rx_misrouted %0d done_before_idle %0d want all 0", cs_change_cnt, rxbad_cnt, done_not_idle); end
        checks++; if ({bus.gnt, bus.busy} !== 5'b0) begin errors++; $display("FAIL single_release: got gnt %b busy %b want 0000 0", bus.gnt, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [15:0] order;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        clear_logs();
        rq_bytes[0][0] = 8'h11; rq_bytes[0][1] = 8'h22;
        rq_bytes[2][0] = 8'h33; rq_bytes[2][1] = 8'h44;
        bus.req_len[0*LENW +: LENW] = 8'd1; bus.req_len[2*LENW +: LENW] = 8'd1;
        bus.req_sel[2*SELW +: SELW] = 8'h07;
        bus.req = 4'b0101;
        for (int k = 0; k < 300 && gnt_log.size() < 4; k++) tick();
        bus.req = 4'b0000;
        for (int k = 0; k < 100 && bus.busy; k++) tick();
        repeat (3) tick();
        order = '0;
        for (int i = 0; i < gnt_log.size() && i < 4; i++) order = {order[11:0], gnt_log[i]};
        checks++; if (gnt_log.size() !== 4 || order !== 16'h1414) begin errors++; $display("FAIL rr_order: got %0d grants %h want 4 grants 1414", gnt_log.size(), order); end
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rr_overlap: got %0d want 0", overlap_cnt); end
        checks++; if (busy_rise !== 4) begin errors++; $display("FAIL rr_busy_gap: got %0d busy rises want 4", busy_rise); end
        checks++; if (tx_log.size() !== 4 || pack_tx() !== 32'h11332244) begin errors++; $display("FAIL rr_tx: got %0d bytes %h want 4 bytes 11332244", tx_log.size(), pack_tx()); end
        checks++; if (done_cnt[0] !== 2 || done_cnt[2] !== 2) begin errors++; $display("FAIL rr_done: got %0d/%0d want 2/2", done_cnt[0], done_cnt[2]); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        bus.req_len[1*LENW +: LENW] = 8'd0; bus.req_sel[1*SELW +: SELW] = 8'h05;
        bus.req[1] = 1'b1;
        for (int k = 0; k < 20 && bus.gnt == '0; k++) tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL zl_gnt: got %b want 0010", bus.gnt); end
        bus.req[1] = 1'b0;
        repeat (5) tick();
        checks++; if (gnt_cycles !== 2) begin errors++; $display("FAIL zl_gnt_cycles: got %0d want 2", gnt_cycles); end
        checks++; if (done_cnt[1] !== 1) begin errors++; $display("FAIL zl_done: got %0d want 1", done_cnt[1]); end
        checks++; if (tx_log.size() !== 0 || dreq_cnt[1] !== 0) begin errors++; $display("FAIL zl_no_tx: got %0d tx %0d dreq want 0 0", tx_log.size(), dreq_cnt[1]); end
    endtask

    task automatic test_timeout();
        clear_logs();
        rq_mute[3] = 1'b1;
        bus.req_len[3*LENW +: LENW] = 8'd2; bus.req_sel[3*SELW +: SELW] = 8'h09;
        bus.req[3] = 1'b1;
        for (int k = 0; k < 20 && bus.gnt == '0; k++) tick();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL to_gnt: got %b want 1000", bus.gnt); end
        bus.req[3] = 1'b0;
        for (int k = 0; k < 100 && err_cnt[3] == 0; k++) tick();
        repeat (4) tick();
        checks++; if (err_cnt[3] !== 1) begin errors++; $display("FAIL to_err: got %0d want 1", err_cnt[3]); end
        checks++; if (err_cyc - dreq_cyc !== 15) begin errors++; $display("FAIL to_latency: got %0d want 15", err_cyc - dreq_cyc); end
        checks++; if (tx_log.size() !== 0 || done_cnt[3] !== 0) begin errors++; $display("FAIL to_quiet: got %0d tx %0d done want 0 0", tx_log.size(), done_cnt[3]); end
        checks++; if ({bus.gnt, bus.busy} !== 5'b0 || dreq_cnt[3] !== 1) begin errors++; $display("FAIL to_release: got gnt %b busy %b dreq %0d want 0000 0 1", bus.gnt, bus.busy, dreq_cnt[3]); end
    endtask

    task automatic test_drop_req();
        clear_logs();
        rq_bytes[0][0] = 8'h01; rq_bytes[0][1] = 8'h02; rq_bytes[0][2] = 8'h03; rq_bytes[0][3] = 8'h04;
        bus.req_len[0*LENW +: LENW] = 8'd4;
        bus.req[0] = 1'b1;
        for (int k = 0; k < 50 && tx_log.size() < 1; k++) tick();
        bus.req[0] = 1'b0;
        for (int k = 0; k < 300 && done_cnt[0] == 0; k++) tick();
        repeat (3) tick();
        checks++; if (tx_log.size() !== 4 || pack_tx() !== 32'h01020304) begin errors++; $display("FAIL drop_tx: got %0d bytes %h want 4 bytes 01020304", tx_log.size(), pack_tx()); end
        checks++; if (dreq_cnt[0] !== 4 || rx_log.size() !== 4) begin errors++; $display("FAIL drop_counts: got %0d dreq %0d rx want 4 4", dreq_cnt[0], rx_log.size()); end
        checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL drop_done: got %0d want 1", done_cnt[0]); end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        rq_bytes[1][0] = 8'hC1; rq_bytes[1][1] = 8'hC2; rq_bytes[1][2] = 8'hC3; rq_bytes[1][3] = 8'hC4;
        bus.req_len[1*LENW +: LENW] = 8'd4; bus.req_sel[1*SELW +: SELW] = 8'h05;
        bus.req[1] = 1'b1;
        for (int k = 0; k < 20 && bus.gnt == '0; k++) tick();
        bus.req[1] = 1'b0;
        for (int k = 0; k < 100 && tx_log.size() < 2; k++) tick();
        checks++; if (bus.chip_sel !== 8'h05) begin errors++; $display("FAIL mid_cs_before: got %h want 05", bus.chip_sel); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.gnt, bus.busy, bus.spi_tx_valid} !== 6'b0) begin errors++; $display("FAIL mid_rst_ctrl: got gnt %b busy %b txv %b want 0000 0 0", bus.gnt, bus.busy, bus.spi_tx_valid); end
        checks++; if (bus.chip_sel !== 8'h00) begin errors++; $display("FAIL mid_rst_cs: got %h want 00", bus.chip_sel); end
        rst = 1'b0;
        tick(); tick();
        clear_logs();
        rq_bytes[0][0] = 8'hD0; rq_bytes[1][0] = 8'hD1;
        bus.req_len[0*LENW +: LENW] = 8'd1; bus.req_len[1*LENW +: LENW] = 8'd1;
        bus.req = 4'b0011;
        for (int k = 0; k < 20 && bus.gnt == '0; k++) tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_ptr_reset: got %b want 0001", bus.gnt); end
        bus.req = 4'b0000;
        for (int k = 0; k < 100 && done_cnt[0] == 0; k++) tick();
        repeat (3) tick();
        checks++; if (done_cnt[0] !== 1 || tx_log.size() !== 1 || pack_tx() !== 32'h000000D0) begin errors++; $display("FAIL mid_fresh_frame: got done %0d tx %0d bytes %h want 1 1 000000d0", done_cnt[0], tx_log.size(), pack_tx()); end
    endtask

    initial begin
        bus.req = '0; bus.req_sel = '0; bus.req_len = '0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 8; j++) rq_bytes[i][j] = '0;
        clear_logs();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_timeout();
        test_drop_req();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tc_pl_bus_arb.md
Name: tc_pl_bus_arb

Overview:
- Round-robin arbiter and frame sequencer that shares the single PL SPI master and its chip-select mux among NREQ requesters (e.g. the GP0 register path plus hardware pollers for ADC0/LPL0).
- Sits between the requesters and the SPI master / CSN mux.
- Grants one requester at a time and drives the chip-select code for the whole frame.
- Pulls exactly `len` bytes from the granted requester and routes received bytes back to it.
- Releases the grant only after the master returns idle; aborts on a stalled requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, SPI byte width; matches the master data width.
- SELW, 8, chip-select code width; matches the CSN mux select.
- LENW, 8, frame length width in bytes.
- TOUT, 1023, cycles to wait for a requester's byte before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester frame request (level).
- req_sel  in  NREQ*SELW  chip-select code; requester i uses slice i.
- req_len  in  NREQ*LENW  frame length in bytes, slice i.
- req_valid  in  NREQ  byte-valid from requester i.
- req_data  in  NREQ*DW  byte from requester i.
- gnt  out  NREQ  one-hot grant.
- req_dreq  out  NREQ  one-cycle byte-request pulse to the granted requester.
- rx_data  out  DW  received byte, broadcast to all requesters.
- rx_valid  out  NREQ  one-cycle pulse, set on the granted bit only.
- done  out  NREQ  one-cycle frame-complete pulse.
- err  out  NREQ  one-cycle abort pulse.
- busy  out  1  high from grant until release.
- spi_tx_idle  in  1  master idle (CSN high).
- spi_tx_dreq  in  1  master requests next byte.
- spi_tx_valid  out  1  byte-valid to master.
- spi_tx_data  out  DW  byte to master.
- spi_rx_valid  in  1  master received byte.
- spi_rx_data  in  DW  master received byte.
- chip_sel  out  SELW  chip-select code to CSN mux.

Behaviour:
- Reset:
  - gnt, req_dreq, rx_valid, done, err, busy, spi_tx_valid = 0.
  - spi_tx_data = 0, rx_data = 0, chip_sel = 0.
  - Priority pointer = 0, state = IDLE.
- IDLE: when any req bit is high and spi_tx_idle=1, go to ARB. Otherwise stay.
- ARB (1 cycle):
  - Pick the first set req bit at or after the pointer, wrapping modulo NREQ.
  - Register gnt, latch sel/len of the winner, assert busy, drive chip_sel.
  - Clear tx_cnt and rx_cnt. Go to LOAD.
- LOAD (1 cycle):
  - len==0: skip SPI, go to DONE.
  - Else pulse req_dreq[g], start the timeout counter, go to WAITB.
- WAITB: on req_valid[g], drive spi_tx_valid=1 with spi_tx_data=req_data[g] for exactly 1 cycle, increment tx_cnt, go to XFER.
- XFER:
  - On spi_tx_dreq with tx_cnt<len: pulse req_dreq[g] next cycle, go to WAITB.
  - spi_tx_dreq with tx_cnt==len is ignored; the master ends the frame.
- Receive path, in any state after LOAD:
  - spi_rx_valid copies spi_rx_data to rx_data and pulses rx_valid[g], both registered with 1-cycle latency.
  - Increment rx_cnt.
  - rx_valid while not busy is dropped.
- Frame end: when tx_cnt==len, rx_cnt==len and spi_tx_idle=1, go to DONE.
- DONE (1 cycle):
  - Pulse done[g], clear gnt and busy.
  - Set pointer to g+1, wrapping.
  - Go to IDLE; a new ARB is possible 1 cycle later.
- Timeout:
  - The counter runs only in WAITB.
  - On reaching TOUT: pulse err[g], do not send a byte, wait for spi_tx_idle=1, then release exactly as DONE but without the done pulse.
- Rules:
  - req is sampled only in ARB. Dropping req mid-frame does not abort the frame.
  - chip_sel and the latched len stay stable for the whole grant.
  - At most one spi_tx_valid per master dreq, plus the initial byte.
  - A req_valid outside WAITB is ignored.
- Simultaneous events: DONE and a new req in the same cycle give done first; the new request is arbitrated after IDLE.
- Reset mid-frame: all state clears immediately and outputs return to reset values next cycle.

Test Plan:
- Single requester 0, sel=0x02, len=3, data A5,5A,FF -> gnt=0001; 3 spi_tx_valid beats with those bytes; 3 rx_valid[0] pulses carrying the looped-back MISO bytes; done[0] after spi_tx_idle rises; chip_sel=0x02 throughout.
- Requesters 0 and 2 both held high, len=1 each -> grant order 0,2,0,2; no two grants overlap; busy drops for ≥1 cycle between frames.
- len=0 on requester 1 -> gnt=0010 for 2 cycles; done[1]; no spi_tx_valid emitted.
- Requester 3 never answers req_dreq, TOUT=15 -> err[3] 15 cycles after entering WAITB; no spi_tx_valid; grant released; done stays 0.
- Requester deasserts req after 1 of 4 bytes -> all 4 bytes still requested and sent; done pulses.
- rst asserted mid-frame after byte 2 -> next cycle gnt=0, busy=0, spi_tx_valid=0, chip_sel=0; a fresh request after rst is served from requester 0 with pointer=0.
